// File: rtl/karatsuba8_job_ctrl.sv
// Job sequencer for the 8-bit Karatsuba multiplier: operand FIFO, start/done handshake,
// timeout abort and a registered product output with valid/ready.
module karatsuba8_job_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_x,
  input  logic [7:0]                   in_y,
  output logic                         mul_start,
  output logic [7:0]                   mul_x,
  output logic [7:0]                   mul_y,
  input  logic                         mul_done,
  input  logic [15:0]                  mul_p,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_p,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [7:0]    fifo_x [DEPTH];
  logic [7:0]    fifo_y [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] tcnt;
  logic          push;
  logic          pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  // Only start a job when its result will have somewhere to land.
  assign pop       = (state == IDLE) && (count != '0) && (!out_valid || out_ready);
  assign mul_start = (state == RUN);
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr] <= in_x;
      fifo_y[wr_ptr] <= in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      tcnt      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            mul_x <= fifo_x[rd_ptr];
            mul_y <= fifo_y[rd_ptr];
            tcnt  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          tcnt <= tcnt + 1'b1;
          if (mul_done) begin
            out_p     <= mul_p;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= DRAIN;
          end
        end
        // Wait out a lingering done so it is never mistaken for the next result.
        DRAIN: begin
          if (!mul_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/karatsuba8_job_ctrl.md
Name: karatsuba8_job_ctrl

Overview:
Upstream sequencer for the 8-bit Karatsuba multiplier (control unit plus datapath). It accepts operand pairs over a valid/ready interface and buffers them in a small FIFO. It drives the multiplier's start/done handshake one job at a time and returns each 16-bit product over a valid/ready output. Operands stay stable for the whole multiplication, and start is released so the multiplier can return to its wait state between jobs.

Parameters:
DEPTH, 4, operand FIFO depth in entries; power of 2, >= 2
TIMEOUT, 15, max cycles in RUN without mul_done before the job is aborted; >= 9

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset; also fans out to the multiplier
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept; = (count < DEPTH)
in_x  in  8  multiplicand
in_y  in  8  multiplier
mul_start  out  1  start to multiplier; = (state == RUN)
mul_x  out  8  registered operand x, held stable from pop until the job leaves DRAIN
mul_y  out  8  registered operand y, same rule
mul_done  in  1  multiplier done flag
mul_p  in  16  multiplier product, valid while mul_done = 1
out_valid  out  1  out_p holds an unconsumed product
out_ready  in  1  consumer accepts out_p
out_p  out  16  product register
busy  out  1  state != IDLE or count != 0
count  out  $clog2(DEPTH+1)  FIFO occupancy
err  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Reset, on the edge where rst = 1:
  - state IDLE; FIFO pointers and count 0.
  - mul_x, mul_y, out_p all 0; out_valid 0; err 0; timeout counter 0.
  - rst has priority over every other event.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only on the IDLE->RUN transition.
  - in_ready depends on count only. When full, a same-cycle pop does not admit a push.
  - A push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH. Entries leave in arrival order.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when count != 0 and (out_valid == 0 or out_ready == 1). On that edge, the FIFO head is popped into mul_x/mul_y and the timeout counter is cleared.
  - RUN: mul_start = 1; the timeout counter increments each cycle.
    - If mul_done = 1 is sampled: capture mul_p into out_p, set out_valid, go to DRAIN.
    - Else if counter == TIMEOUT - 1: set err, go to DRAIN, discard the job (out_valid unchanged).
  - DRAIN: mul_start = 0. Go to IDLE on the first edge where mul_done = 0. This stops a lingering done from being taken as the next result.
- Output register:
  - out_valid clears on out_valid && out_ready unless the same edge captures a new product; capture wins, and gating makes this case unreachable.
  - out_p is held while out_valid = 1.
- Latency: with a multiplier whose done rises 8 edges after start is first high, out_valid rises 9 edges after the pop edge.
  - Minimum spacing between pops = multiplier latency + 2 cycles (RUN exit + DRAIN).
- Width rules: no truncation; out_p = mul_p exactly; operands unsigned.
- Reset mid-operation: the job in flight and all queued jobs are lost, and no result is produced for them.

Test Plan:
1. Single job: push x=13, y=11; out_ready=1 -> mul_start high from the pop edge until mul_done is sampled; mul_x=13 and mul_y=11 stable throughout; out_p=0x008F with one out_valid pulse; busy returns to 0.
2. Burst, DEPTH=4, out_ready=1: push (255,255), (0,77), (1,200), (16,16), (3,5), (2,2) on back-to-back cycles -> in_ready drops at count=4; outputs in order 0xFE01, 0x0000, 0x00C8, 0x0100, 0x000F, 0x0004; FIFO wraps without loss.
3. Backpressure: out_ready=0, two jobs queued -> after the first result, mul_start stays 0 and out_p is held. Raise out_ready -> the second job pops on that same edge.
4. Timeout: mul_done tied 0, one job -> exactly TIMEOUT cycles of mul_start=1, then err=1, out_valid stays 0, state returns to IDLE. Release mul_done and queue a new job -> it completes normally with err still 1.
5. Lingering done: hold mul_done=1 for 3 extra cycles after capture -> the FSM stays in DRAIN, no new pop, and no second capture until mul_done=0.
6. Reset mid-RUN with 3 jobs queued: assert rst for one edge -> next cycle count=0, out_valid=0, err=0, mul_start=0; no stale result ever appears.
